// File: rtl/reg_slice_pkg.sv
// Shared types and defaults for the register-slice skid buffer.
// State encoding doubles as the occupancy count seen on the occupancy port.
package reg_slice_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } slice_state_t;

endpackage

// File: rtl/reg_slice_stage.sv
// WIDTH-bit holding register with synchronous active-low clear and load enable.
module reg_slice_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_slice_w4_skid.sv
// Two-entry skid buffer: fully registered valid/ready stream stage with no
// combinational path from out_ready to in_ready.
module reg_slice_w4_skid
  import reg_slice_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  // Handshake: a word moves across a port only on a rising edge where that
  // port's valid and ready are both high; valid never waits on ready, and
  // a presented word holds steady until it fires.
  slice_state_t     state_q, state_d;
  logic             in_fire, out_fire;
  logic             load_main, load_skid;
  logic [WIDTH-1:0] main_q, skid_q, main_d;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Refilling main from a full slice always comes from the skid entry.
  assign main_d = (state_q == TWO) ? skid_q : in_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  reg_slice_stage #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_main),
    .d     (main_d),
    .q     (main_q)
  );

  reg_slice_stage #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_skid),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_reg_slice_w4_skid.sv
// Directed vector table plus a randomized valid/ready run checked against a
// queue model of the two-entry buffer.
module tb_reg_slice_w4_skid;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;
  logic [1:0] occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp_q[$];

  reg_slice_w4_skid #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       iv;
    logic [3:0] id;
    logic       ordy;
    logic       ov;
    logic [3:0] od;
    logic [1:0] occ;
    logic       ir;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs[NVEC];

  function automatic vec_t mk(logic r, logic iv, logic [3:0] id, logic ordy,
                              logic ov, logic [3:0] od, logic [1:0] occ, logic ir);
    vec_t v;
    v.rst_n = r;  v.iv = iv;  v.id = id;   v.ordy = ordy;
    v.ov    = ov; v.od = od;  v.occ = occ; v.ir   = ir;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [3:0] act,
                       input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [3:0] id,
                       input logic ordy);
    rst_n     = r;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
  endtask

  initial begin
    // reset, 2 edges
    vecs[0]  = mk(0, 0, 4'h0, 0,  0, 4'h0, 2'd0, 1);
    vecs[1]  = mk(0, 0, 4'h0, 0,  0, 4'h0, 2'd0, 1);
    // streaming 5, A, 3 with out_ready high
    vecs[2]  = mk(1, 1, 4'h5, 1,  1, 4'h5, 2'd1, 1);
    vecs[3]  = mk(1, 1, 4'hA, 1,  1, 4'hA, 2'd1, 1);
    vecs[4]  = mk(1, 1, 4'h3, 1,  1, 4'h3, 2'd1, 1);
    vecs[5]  = mk(1, 0, 4'h0, 1,  0, 4'h3, 2'd0, 1);
    // stall: 5 then A fill the slice, F is ignored, then drain
    vecs[6]  = mk(1, 1, 4'h5, 0,  1, 4'h5, 2'd1, 1);
    vecs[7]  = mk(1, 1, 4'hA, 0,  1, 4'h5, 2'd2, 0);
    vecs[8]  = mk(1, 1, 4'hF, 0,  1, 4'h5, 2'd2, 0);
    vecs[9]  = mk(1, 1, 4'hF, 1,  1, 4'hA, 2'd1, 1);
    vecs[10] = mk(1, 0, 4'h0, 1,  0, 4'hA, 2'd0, 1);
    // simultaneous in_fire and out_fire while holding one word
    vecs[11] = mk(1, 1, 4'h5, 0,  1, 4'h5, 2'd1, 1);
    vecs[12] = mk(1, 1, 4'hA, 1,  1, 4'hA, 2'd1, 1);
    vecs[13] = mk(1, 0, 4'h0, 1,  0, 4'hA, 2'd0, 1);
    // reset while full discards both words
    vecs[14] = mk(1, 1, 4'h5, 0,  1, 4'h5, 2'd1, 1);
    vecs[15] = mk(1, 1, 4'hA, 0,  1, 4'h5, 2'd2, 0);
    vecs[16] = mk(0, 0, 4'h0, 0,  0, 4'h0, 2'd0, 1);
    vecs[17] = mk(1, 0, 4'h0, 1,  0, 4'h0, 2'd0, 1);
    vecs[18] = mk(1, 0, 4'h0, 1,  0, 4'h0, 2'd0, 1);
    // X on in_data with in_valid low must not reach out_data
    vecs[19] = mk(1, 0, 4'bxxxx, 1,  0, 4'h0, 2'd0, 1);
    vecs[20] = mk(1, 1, 4'h6,    1,  1, 4'h6, 2'd1, 1);
    vecs[21] = mk(1, 0, 4'bxxxx, 0,  1, 4'h6, 2'd1, 1);
    vecs[22] = mk(1, 0, 4'bxxxx, 1,  0, 4'h6, 2'd0, 1);

    drive(0, 0, 4'h0, 0);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].rst_n, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      @(posedge clk);
      #1;
      check("out_valid", i, {3'b0, out_valid}, {3'b0, vecs[i].ov});
      check("out_data",  i, out_data,          vecs[i].od);
      check("occupancy", i, {2'b0, occupancy}, {2'b0, vecs[i].occ});
      check("in_ready",  i, {3'b0, in_ready},  {3'b0, vecs[i].ir});
    end

    // random valid/ready against a queue model; slice is empty here
    exp_q.delete();
    for (int c = 0; c < 10000; c++) begin
      logic iv, ordy, in_fire_m, out_fire_m;
      logic [3:0] id;
      @(negedge clk);
      iv   = ($urandom_range(0, 3) != 0);
      id   = 4'($urandom_range(0, 15));
      ordy = ($urandom_range(0, 2) != 0);
      drive(1, iv, id, ordy);
      in_fire_m  = iv && (exp_q.size() < 2);
      out_fire_m = ordy && (exp_q.size() > 0);
      @(posedge clk);
      if (out_fire_m) void'(exp_q.pop_front());
      if (in_fire_m) exp_q.push_back(id);
      #1;
      check("rnd_out_valid", c, {3'b0, out_valid}, {3'b0, (exp_q.size() > 0)});
      check("rnd_in_ready",  c, {3'b0, in_ready},  {3'b0, (exp_q.size() < 2)});
      check("rnd_occupancy", c, {2'b0, occupancy}, 4'(exp_q.size()));
      if (exp_q.size() > 0) check("rnd_out_data", c, out_data, exp_q[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
